spi_cmd_wb_master: RTL and testbench

Consumes bytes assembled by the SPI slave byte receiver, already transferred into the in_clk domain as a one-cycle valid strobe. Decodes a simple command framing: byte 0 is the command/address, and following bytes are data. Each access becomes a pipelined Wishbone master cycle to the on-chip register bank, with auto-incrementing bursts. Provides the read-back byte to the SPI transmit path, plus sticky error flags.

---
 rtl/spi_pkg.sv | 16 +
 rtl/wb_single_master.sv | 53 +++++
 rtl/spi_cmd_wb_master.sv | 141 ++++++++++++++
 tb/tb_spi_cmd_wb_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared encodings and constants for the SPI command to Wishbone bridge.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_BUS     = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_e;

    localparam int unsigned CMD_WE_BIT      = 7;
    localparam int unsigned DEF_ACK_TIMEOUT = 15;
    localparam logic [7:0]  TX_IDLE_BYTE    = 8'hFF;

endpackage

// File: rtl/wb_single_master.sv
// One-outstanding pipelined Wishbone handshake: raises cyc/stb on request, drops stb
// on acceptance, then waits for ack or abandons the cycle after ACK_TIMEOUT cycles.
module wb_single_master
    import spi_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic wb_stall_i,
    input  logic wb_ack_i,
    output logic wb_cyc_o,
    output logic wb_stb_o,
    output logic done_o,
    output logic timeout_o
);

    logic       cyc_q;
    logic       stb_q;
    logic [7:0] cnt_q;

    // done/timeout are combinational so the parent can react on the same edge that ends the cycle.
    assign done_o    = cyc_q && wb_ack_i;
    assign timeout_o = cyc_q && !stb_q && !wb_ack_i && (cnt_q == 8'(ACK_TIMEOUT - 1));

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            cnt_q <= '0;
        end else if (done_o || timeout_o) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
        end else if (!cyc_q) begin
            if (req_i) begin
                cyc_q <= 1'b1;
                stb_q <= 1'b1;
                cnt_q <= '0;
            end
        end else if (stb_q) begin
            if (!wb_stall_i) stb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_cmd_wb_master.sv
// Decodes SPI command frames (command/address byte then data bytes) into
// auto-incrementing Wishbone accesses, returning read data to the SPI transmitter.
module spi_cmd_wb_master
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_cs_n,
    input  logic              in_rx_valid,
    input  logic [7:0]        in_rx_byte,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_load,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [7:0]        o_wb_data,
    input  logic              in_wb_stall,
    input  logic              in_wb_ack,
    input  logic [7:0]        in_wb_data,
    input  logic              in_err_clr,
    output logic              o_err_timeout,
    output logic              o_err_overrun
);

    state_e            state_q;
    logic              we_q;
    logic              abort_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        tx_byte_q;
    logic              tx_load_q;
    logic              err_to_q;
    logic              err_ov_q;

    logic bus_start;
    logic bus_done;
    logic bus_timeout;
    logic abort;

    // The strobe launches on the same edge the FSM enters BUS.
    assign bus_start = !in_cs_n && in_rx_valid &&
                       ((state_q == ST_CMD && !in_rx_byte[CMD_WE_BIT]) ||
                        state_q == ST_WR_DATA || state_q == ST_RD_WAIT);
    assign abort     = abort_q || in_cs_n;

    wb_single_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .req_i      (bus_start),
        .wb_stall_i (in_wb_stall),
        .wb_ack_i   (in_wb_ack),
        .wb_cyc_o   (o_wb_cyc),
        .wb_stb_o   (o_wb_stb),
        .done_o     (bus_done),
        .timeout_o  (bus_timeout)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_byte_q <= '0;
            tx_load_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            tx_load_q <= 1'b0;
            // Clear first so an error set later in this block wins.
            if (in_err_clr) begin
                err_to_q <= 1'b0;
                err_ov_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: if (!in_cs_n) state_q <= ST_CMD;
                ST_CMD: begin
                    if (in_cs_n) begin
                        state_q <= ST_IDLE;
                    end else if (in_rx_valid) begin
                        we_q    <= in_rx_byte[CMD_WE_BIT];
                        addr_q  <= in_rx_byte[ADDR_W-1:0];
                        state_q <= in_rx_byte[CMD_WE_BIT] ? ST_WR_DATA : ST_BUS;
                    end
                end
                ST_WR_DATA: begin
                    if (in_cs_n) begin
                        state_q <= ST_IDLE;
                    end else if (in_rx_valid) begin
                        wdata_q <= in_rx_byte;
                        state_q <= ST_BUS;
                    end
                end
                ST_RD_WAIT: begin
                    if (in_cs_n) state_q <= ST_IDLE;
                    else if (in_rx_valid) state_q <= ST_BUS;
                end
                ST_BUS: begin
                    if (in_rx_valid) err_ov_q <= 1'b1;
                    if (in_cs_n) abort_q <= 1'b1;
                    if (bus_done) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        abort_q <= 1'b0;
                        if (we_q) begin
                            state_q <= abort ? ST_IDLE : ST_WR_DATA;
                        end else begin
                            tx_byte_q <= in_wb_data;
                            tx_load_q <= !abort;
                            state_q   <= abort ? ST_IDLE : ST_RD_WAIT;
                        end
                    end else if (bus_timeout) begin
                        err_to_q <= 1'b1;
                        abort_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (!we_q) begin
                            tx_byte_q <= TX_IDLE_BYTE;
                            tx_load_q <= !abort;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_byte     = tx_byte_q;
    assign o_tx_load     = tx_load_q;
    assign o_wb_we       = we_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_data     = wdata_q;
    assign o_err_timeout = err_to_q;
    assign o_err_overrun = err_ov_q;

endmodule

// File: tb/tb_spi_cmd_wb_master.sv
// Directed bench for spi_cmd_wb_master: a write-vector table plus hand-written
// burst-read, stall, timeout, overrun, abort and reset sequences against a slave model.
module tb_spi_cmd_wb_master;
    import spi_pkg::*;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_cs_n = 1'b1;
    logic       in_rx_valid = 1'b0;
    logic [7:0] in_rx_byte = '0;
    logic [7:0] o_tx_byte;
    logic       o_tx_load;
    logic       o_wb_cyc, o_wb_stb, o_wb_we;
    logic [6:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       in_wb_stall = 1'b0;
    logic       in_wb_ack = 1'b0;
    logic [7:0] in_wb_data = '0;
    logic       in_err_clr = 1'b0;
    logic       o_err_timeout, o_err_overrun;

    spi_cmd_wb_master #(.ADDR_W(7), .ACK_TIMEOUT(15)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_cs_n(in_cs_n),
        .in_rx_valid(in_rx_valid), .in_rx_byte(in_rx_byte),
        .o_tx_byte(o_tx_byte), .o_tx_load(o_tx_load),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .in_wb_stall(in_wb_stall), .in_wb_ack(in_wb_ack), .in_wb_data(in_wb_data),
        .in_err_clr(in_err_clr), .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun)
    );

    always #5 in_clk = ~in_clk;

    // Slave configuration, written only by the stimulus process.
    int         ack_delay = 2;
    int         stall_cycles = 0;
    bit         no_ack = 1'b0;
    bit         force_ack = 1'b0;
    logic [7:0] mem [128];

    // Slave and monitor state, written only by the negedge process.
    bit         pending = 1'b0;
    int         wait_cnt = 0;
    int         stall_cnt = 0;
    logic [6:0] cur_addr = '0;
    logic       log_we [$];
    logic [6:0] log_addr [$];
    logic [7:0] log_data [$];
    logic [7:0] tx_log [$];
    int         loads_after_ack = 0;
    int         stb_cycles = 0;
    int         cyc_only_cycles = 0;

    always @(negedge in_clk) begin
        if (o_tx_load) begin
            tx_log.push_back(o_tx_byte);
            if (in_wb_ack) loads_after_ack++;
        end
        if (o_wb_stb) stb_cycles++;
        if (o_wb_cyc && !o_wb_stb) cyc_only_cycles++;

        in_wb_ack   = force_ack;
        in_wb_stall = 1'b0;
        if (!o_wb_cyc) pending = 1'b0;
        if (!o_wb_stb) stall_cnt = 0;
        if (o_wb_stb && !pending) begin
            if (stall_cnt < stall_cycles) begin
                in_wb_stall = 1'b1;
                stall_cnt++;
            end else begin
                pending   = 1'b1;
                wait_cnt  = 0;
                stall_cnt = 0;
                cur_addr  = o_wb_addr;
                log_we.push_back(o_wb_we);
                log_addr.push_back(o_wb_addr);
                log_data.push_back(o_wb_data);
            end
        end else if (pending) begin
            wait_cnt++;
            if (!no_ack && wait_cnt == ack_delay) begin
                in_wb_ack  = 1'b1;
                in_wb_data = mem[cur_addr];
                pending    = 1'b0;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge in_clk);
        in_rx_valid = 1'b1;
        in_rx_byte  = b;
        @(negedge in_clk);
        in_rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge in_clk);
        in_cs_n = 1'b0;
        tick(2);
    endtask

    task automatic frame_end();
        @(negedge in_clk);
        in_cs_n = 1'b1;
        tick(3);
    endtask

    task automatic wait_bus(input string name);
        int n = 0;
        while (o_wb_cyc && n < 100) begin
            @(negedge in_clk);
            n++;
        end
        check(name, 32'(o_wb_cyc), 32'd0);
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
                    o_tx_byte, o_tx_load, o_err_timeout, o_err_overrun});
    endfunction

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         dly;
        logic [6:0] exp_addr;
        logic [7:0] exp_data;
    } wr_vec_t;

    wr_vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int base, tx_base, cnt_base;

        vecs[0] = '{8'h85, 8'h3C, 2, 7'h05, 8'h3C};
        vecs[1] = '{8'h80, 8'h00, 1, 7'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hA5, 3, 7'h7F, 8'hA5};
        vecs[3] = '{8'hC3, 8'h5A, 1, 7'h43, 8'h5A};
        vecs[4] = '{8'h8A, 8'hFF, 4, 7'h0A, 8'hFF};
        for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5C);
        mem[7'h7F] = 8'hA1;
        mem[7'h00] = 8'hA2;
        mem[7'h10] = 8'h5E;

        tick(3);
        check("reset_outputs", all_outputs(), 32'd0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        tick(2);
        check("reset_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Write-vector table.
        for (int i = 0; i < 5; i++) begin
            ack_delay = vecs[i].dly;
            base = log_addr.size();
            frame_start();
            send_byte(vecs[i].cmd);
            tick(1);
            send_byte(vecs[i].data);
            wait_bus($sformatf("wr%0d_ack_wait", i));
            frame_end();
            check($sformatf("wr%0d_count", i), 32'(log_addr.size()), 32'(base + 1));
            if (log_addr.size() > base) begin
                check($sformatf("wr%0d_addr", i), 32'(log_addr[base]), 32'(vecs[i].exp_addr));
                check($sformatf("wr%0d_data", i), 32'(log_data[base]), 32'(vecs[i].exp_data));
                check($sformatf("wr%0d_we", i), 32'(log_we[base]), 32'd1);
            end
            check($sformatf("wr%0d_errs", i), 32'({o_err_timeout, o_err_overrun}), 32'd0);
            check($sformatf("wr%0d_idle", i), 32'(dut.state_q), 32'(ST_IDLE));
        end

        // Burst read with address wrap 7F -> 00.
        ack_delay = 2;
        base = log_addr.size();
        tx_base = tx_log.size();
        cnt_base = loads_after_ack;
        frame_start();
        send_byte(8'h7F);
        wait_bus("rd_ack_wait0");
        tick(2);
        send_byte(8'h00);
        wait_bus("rd_ack_wait1");
        tick(2);
        frame_end();
        check("rd_count", 32'(log_addr.size()), 32'(base + 2));
        check("rd_tx_count", 32'(tx_log.size()), 32'(tx_base + 2));
        check("rd_latency", 32'(loads_after_ack), 32'(cnt_base + 2));
        if (log_addr.size() >= base + 2 && tx_log.size() >= tx_base + 2) begin
            check("rd_addr0", 32'(log_addr[base]), 32'h7F);
            check("rd_addr1", 32'(log_addr[base + 1]), 32'h00);
            check("rd_we", 32'({log_we[base], log_we[base + 1]}), 32'd0);
            check("rd_tx0", 32'(tx_log[tx_base]), 32'hA1);
            check("rd_tx1", 32'(tx_log[tx_base + 1]), 32'hA2);
        end

        // Stall then the longest legal ack delay: timeout counts from acceptance only.
        stall_cycles = 3;
        ack_delay = 15;
        base = log_addr.size();
        cnt_base = stb_cycles;
        frame_start();
        send_byte(8'h8F);
        tick(1);
        send_byte(8'h77);
        wait_bus("stall_ack_wait");
        frame_end();
        stall_cycles = 0;
        check("stall_stb_cycles", 32'(stb_cycles - cnt_base), 32'd4);
        check("stall_count", 32'(log_addr.size()), 32'(base + 1));
        if (log_addr.size() > base)
            check("stall_data", 32'(log_data[base]), 32'h77);
        check("stall_no_timeout", 32'(o_err_timeout), 32'd0);

        // Read timeout.
        no_ack = 1'b1;
        tx_base = tx_log.size();
        cnt_base = cyc_only_cycles;
        frame_start();
        send_byte(8'h30);
        wait_bus("to_wait");
        tick(1);
        check("to_cycles", 32'(cyc_only_cycles - cnt_base), 32'd15);
        check("to_flag", 32'(o_err_timeout), 32'd1);
        check("to_addr_kept", 32'(o_wb_addr), 32'h30);
        check("to_tx_count", 32'(tx_log.size()), 32'(tx_base + 1));
        check("to_tx_byte", 32'(o_tx_byte), 32'hFF);
        @(negedge in_clk);
        in_err_clr = 1'b1;
        @(negedge in_clk);
        in_err_clr = 1'b0;
        check("to_cleared", 32'(o_err_timeout), 32'd0);
        frame_end();
        no_ack = 1'b0;

        // Overrun during BUS, with a simultaneous clear that must lose.
        ack_delay = 5;
        base = log_addr.size();
        frame_start();
        send_byte(8'h81);
        tick(1);
        send_byte(8'h11);
        @(negedge in_clk);
        in_rx_valid = 1'b1;
        in_rx_byte  = 8'h22;
        in_err_clr  = 1'b1;
        @(negedge in_clk);
        in_rx_valid = 1'b0;
        in_err_clr  = 1'b0;
        check("ov_flag", 32'(o_err_overrun), 32'd1);
        wait_bus("ov_ack_wait0");
        tick(1);
        send_byte(8'h33);
        wait_bus("ov_ack_wait1");
        frame_end();
        check("ov_count", 32'(log_addr.size()), 32'(base + 2));
        if (log_addr.size() >= base + 2) begin
            check("ov_first", 32'({log_addr[base], log_data[base]}), 32'h0111);
            check("ov_second", 32'({log_addr[base + 1], log_data[base + 1]}), 32'h0233);
        end
        @(negedge in_clk);
        in_err_clr = 1'b1;
        @(negedge in_clk);
        in_err_clr = 1'b0;
        check("ov_cleared", 32'(o_err_overrun), 32'd0);

        // Chip select released mid-read: cycle completes, no tx load.
        ack_delay = 3;
        base = log_addr.size();
        tx_base = tx_log.size();
        frame_start();
        send_byte(8'h10);
        @(negedge in_clk);
        in_cs_n = 1'b1;
        wait_bus("abort_wait");
        tick(2);
        check("abort_count", 32'(log_addr.size()), 32'(base + 1));
        check("abort_no_load", 32'(tx_log.size()), 32'(tx_base));
        check("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("abort_addr_inc", 32'(o_wb_addr), 32'h11);

        // Ack without a cycle is ignored.
        @(negedge in_clk);
        force_ack = 1'b1;
        @(negedge in_clk);
        force_ack = 1'b0;
        tick(1);
        check("stray_ack_load", 32'(tx_log.size()), 32'(tx_base));
        check("stray_ack_addr", 32'(o_wb_addr), 32'h11);

        // Asynchronous reset in the middle of a bus cycle.
        no_ack = 1'b1;
        frame_start();
        send_byte(8'h20);
        tick(2);
        check("rst_pre_cyc", 32'(o_wb_cyc), 32'd1);
        #2;
        in_rst_n = 1'b0;
        #1;
        check("rst_async_outputs", all_outputs(), 32'd0);
        no_ack = 1'b0;
        @(negedge in_clk);
        in_cs_n = 1'b1;
        in_rst_n = 1'b1;
        tick(2);
        check("rst_idle", 32'(dut.state_q), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
